// File: rtl/accum_pkg.sv
// accum_pkg: shared types for the accumulator feed block.
//   state_t - control FSM states (IDLE, RUN, HALT).
package accum_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

endpackage

// File: rtl/accum_feed_if.sv
// accum_feed_if: valid/ready sample stream into accum_feed.
//   in_valid - sample valid (upstream -> block)
//   in_ready - block can accept (block -> upstream)
//   in_data  - sample, DATA_WIDTH bits
interface accum_feed_if #(
   parameter int DATA_WIDTH = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count and synchronous flush.
//   clk, rst (async, active-high)
//   push/wr_data - write when not full; pop/rd_data - read when not empty
//   flush        - empties the FIFO next cycle, overrides push and pop
//   full, empty, fill - status, all derived from the registered count
module sync_fifo #(
   parameter int DATA_WIDTH = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic                          flush,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   fill
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   // Status comes only from the registered count, so no pop-to-ready path exists.
   assign full    = (fill == FW'(FIFO_DEPTH));
   assign empty   = (fill == {FW{1'b0}});
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rd_data = mem[rd_ptr];

   // Storage array write; contents need no reset since only written entries are read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointer and occupancy update; pointers wrap naturally as FIFO_DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         fill   <= {FW{1'b0}};
      end else if (flush) begin
         wr_ptr <= {AW{1'b0}};
         rd_ptr <= {AW{1'b0}};
         fill   <= {FW{1'b0}};
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1'b1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1'b1);
         end
         case ({do_push, do_pop})
            2'b10:   fill <= fill + FW'(1'b1);
            2'b01:   fill <= fill - FW'(1'b1);
            default: fill <= fill;
         endcase
      end
   end
endmodule

// File: rtl/accum_feed.sv
// accum_feed: buffers an input sample stream and feeds windows of WIN_LEN
// samples to a downstream accumulator, halting on accumulator overflow.
//   clk, rst (async, active-high)
//   in_if    - sample stream (slave side of accum_feed_if)
//   start    - opens a window (IDLE only)
//   clr_halt - leaves HALT, flushing buffered samples (HALT only)
//   acc_ovf  - accumulator overflow; blocks the pop and halts
//   acc_en/acc_data - registered sample to the accumulator
//   win_done - one-cycle pulse with the last sample of a window
//   halted, busy - registered state flags; fill - FIFO occupancy
module accum_feed
   import accum_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int WIN_LEN    = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   accum_feed_if.slave                 in_if,
   input  logic                        start,
   input  logic                        clr_halt,
   input  logic                        acc_ovf,
   output logic                        acc_en,
   output logic [DATA_WIDTH-1:0]       acc_data,
   output logic                        win_done,
   output logic                        halted,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fill
);
   localparam int CW = $clog2(WIN_LEN + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIN_LEN - 1);

   state_t                state;
   logic [CW-1:0]         win_cnt;
   logic                  push;
   logic                  pop;
   logic                  flush;
   logic                  full;
   logic                  empty;
   logic [DATA_WIDTH-1:0] rd_data;

   assign in_if.in_ready = !full;
   assign push           = in_if.in_valid && !full;

   // Pop/flush decode: overflow blocks the pop in the same cycle it is seen.
   always_comb begin
      pop   = 1'b0;
      flush = 1'b0;
      case (state)
         RUN:     pop   = !acc_ovf && !empty;
         HALT:    flush = clr_halt;
         default: begin
            pop   = 1'b0;
            flush = 1'b0;
         end
      endcase
   end

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .wr_data (in_if.in_data),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .fill    (fill)
   );

   // Control FSM with registered accumulator feed and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         win_cnt  <= {CW{1'b0}};
         acc_en   <= 1'b0;
         acc_data <= {DATA_WIDTH{1'b0}};
         win_done <= 1'b0;
         halted   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         acc_en   <= pop;
         win_done <= 1'b0;
         if (pop) begin
            acc_data <= rd_data;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= RUN;
                  win_cnt <= {CW{1'b0}};
                  busy    <= 1'b1;
               end
            end
            RUN: begin
               if (acc_ovf) begin
                  state  <= HALT;
                  busy   <= 1'b0;
                  halted <= 1'b1;
               end else if (pop) begin
                  // This pop brings the count to WIN_LEN: close the window.
                  if (win_cnt == LAST_CNT) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     win_cnt  <= {CW{1'b0}};
                     win_done <= 1'b1;
                  end else begin
                     win_cnt <= win_cnt + CW'(1'b1);
                  end
               end
            end
            HALT: begin
               if (clr_halt) begin
                  state   <= IDLE;
                  halted  <= 1'b0;
                  win_cnt <= {CW{1'b0}};
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               halted  <= 1'b0;
               win_cnt <= {CW{1'b0}};
            end
         endcase
      end
   end
endmodule

// File: tb/tb_accum_feed.sv
// tb_accum_feed: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based reference model of the feed behaviour.
module tb_accum_feed;
   localparam int DW    = 4;
   localparam int DEPTH = 4;
   localparam int WLEN  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          clr_halt = 1'b0;
   logic          acc_ovf = 1'b0;
   logic          acc_en;
   logic [DW-1:0] acc_data;
   logic          win_done;
   logic          halted;
   logic          busy;
   logic [$clog2(DEPTH):0] fill;

   accum_feed_if #(.DATA_WIDTH(DW)) in_if ();

   accum_feed #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .WIN_LEN    (WLEN)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_if    (in_if),
      .start    (start),
      .clr_halt (clr_halt),
      .acc_ovf  (acc_ovf),
      .acc_en   (acc_en),
      .acc_data (acc_data),
      .win_done (win_done),
      .halted   (halted),
      .busy     (busy),
      .fill     (fill)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: mode 0 = idle, 1 = run, 2 = halt
   logic [DW-1:0] mdl_q[$];
   int            mode = 0;
   int            cnt  = 0;
   logic [DW-1:0] m_data = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, advance the model, compare after the edge.
   task automatic step(input bit v, input logic [DW-1:0] d, input bit s, input bit c, input bit o);
      bit rdy, acc, pop, done, fl;
      in_if.in_valid = v;
      in_if.in_data  = d;
      start          = s;
      clr_halt       = c;
      acc_ovf        = o;
      rdy  = (mdl_q.size() != DEPTH);
      chk("in_ready", in_if.in_ready, rdy);
      acc  = v && rdy;
      pop  = 0;
      done = 0;
      fl   = 0;
      if (mode == 0) begin
         if (s) begin mode = 1; cnt = 0; end
      end else if (mode == 1) begin
         if (o) mode = 2;
         else if (mdl_q.size() > 0) begin
            pop = 1;
            cnt++;
            if (cnt == WLEN) begin done = 1; mode = 0; cnt = 0; end
         end
      end else begin
         if (c) begin fl = 1; mode = 0; cnt = 0; end
      end
      if (pop) m_data = mdl_q.pop_front();
      if (fl) mdl_q.delete();
      else if (acc) mdl_q.push_back(d);
      @(posedge clk);
      #1;
      chk("acc_en", acc_en, pop);
      chk("acc_data", acc_data, m_data);
      chk("win_done", win_done, done);
      chk("halted", halted, mode == 2);
      chk("busy", busy, mode == 1);
      chk("fill", fill, mdl_q.size());
   endtask

   task automatic idle_step();
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Reset asserted between edges; outputs must clear without waiting for a clock.
   task automatic mid_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_acc_en", acc_en, 1'b0);
      chk("rst_acc_data", acc_data, 4'd0);
      chk("rst_win_done", win_done, 1'b0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fill", fill, 3'd0);
      mdl_q.delete();
      mode = 0;
      cnt = 0;
      m_data = '0;
      in_if.in_valid = 1'b0;
      start = 1'b0;
      clr_halt = 1'b0;
      acc_ovf = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] seq [4];
      int n_en;
      seq[0] = 4'd3; seq[1] = 4'd5; seq[2] = 4'd7; seq[3] = 4'd1;
      in_if.in_valid = 1'b0;
      in_if.in_data  = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("init_acc_en", acc_en, 1'b0);
      chk("init_busy", busy, 1'b0);
      chk("init_fill", fill, 3'd0);
      @(negedge clk);
      rst = 1'b0;

      // push 3,5,7,1 then start: acc_en on 4 consecutive cycles with that data
      for (int i = 0; i < 4; i++) step(1'b1, seq[i], 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         idle_step();
         chk("seq_en", acc_en, k < 4);
         if (k < 4) chk("seq_data", acc_data, seq[k]);
         chk("seq_done", win_done, k == 3);
      end

      // in_valid held with no start: fill saturates at DEPTH, no feed
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0);
         chk("sat_no_en", acc_en, 1'b0);
      end
      chk("sat_fill", fill, 3'd4);
      chk("sat_ready", in_if.in_ready, 1'b0);

      // overflow on the cycle of the final window pop
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) idle_step();
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      chk("ovf_halted", halted, 1'b1);
      chk("ovf_no_done", win_done, 1'b0);
      chk("ovf_no_en", acc_en, 1'b0);
      chk("ovf_fill", fill, 3'd1);

      // in HALT: accept pushes, then clr_halt flushes
      step(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
      step(1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
      chk("halt_fill", fill, 3'd3);
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      chk("clr_fill", fill, 3'd0);
      chk("clr_halted", halted, 1'b0);
      chk("clr_busy", busy, 1'b0);

      // 6 samples streamed with start: 4 fed, 2 left behind
      n_en = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 4'($urandom), i == 0, 1'b0, 1'b0);
         if (acc_en) n_en++;
         if (acc_en && n_en == 4) chk("stream_done", win_done, 1'b1);
      end
      chk("stream_en_cnt", n_en, 4);
      chk("stream_fill", fill, 3'd2);
      chk("stream_idle", busy, 1'b0);

      // reset mid-window: no feed afterwards until the next start
      step(1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
      step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
      mid_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0);
         chk("post_rst_no_en", acc_en, 1'b0);
      end

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) mid_reset();
         else step($urandom_range(0, 3) != 0, 4'($urandom),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 15) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/accum_feed.md
ACCUM_FEED -- requirements
Module: accum_feed

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4: sample width, equal to the accumulator input width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: input buffer entries, a power of two, at least 2.
REQ-003 The block SHALL have parameter WIN_LEN, default 16: samples per accumulation window, at least 1.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream sample valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept a sample.
REQ-008 The block SHALL have port in_data, input, DATA_WIDTH bits: upstream sample.
REQ-009 The block SHALL have port start, input, 1 bit: pulse that opens a window.
REQ-010 The block SHALL have port clr_halt, input, 1 bit: pulse that clears the halted state.
REQ-011 The block SHALL have port acc_ovf, input, 1 bit: overflow flag returned by the downstream accumulator.
REQ-012 The block SHALL have port acc_en, output, 1 bit: accumulation enable to the accumulator.
REQ-013 The block SHALL have port acc_data, output, DATA_WIDTH bits: sample to the accumulator.
REQ-014 The block SHALL have port win_done, output, 1 bit: one-cycle pulse when a window completes.
REQ-015 The block SHALL have port halted, output, 1 bit: high while in HALT.
REQ-016 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-017 The block SHALL have port fill, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-018 The FIFO SHALL push when in_valid && in_ready, with in_ready = (fill != FIFO_DEPTH), in every state, and with no combinational path from pop to in_ready.
REQ-019 The FSM SHALL have exactly the states IDLE, RUN and HALT.
REQ-020 In IDLE the block SHALL NOT pop, and start SHALL move it to RUN with win_cnt cleared to 0.
REQ-021 In RUN, if acc_ovf is 0 and the FIFO is non-empty, the block SHALL pop one entry per cycle and increment win_cnt; if empty, it SHALL neither pop nor count.
REQ-022 acc_en and acc_data SHALL be registered, appearing exactly 1 cycle after the pop; acc_en SHALL be 0 in cycles without a pop, and acc_data SHALL hold its last value.
REQ-023 The pop that makes win_cnt equal WIN_LEN SHALL return the FSM to IDLE and assert win_done for exactly 1 cycle, coincident with that sample's acc_en.
REQ-024 acc_ovf = 1 in RUN SHALL block the pop in that same cycle and move the FSM to HALT; overflow takes priority over window completion (no pop, no win_done).
REQ-025 In HALT the block SHALL keep acc_en at 0 and keep accepting pushes until the FIFO is full.
REQ-026 clr_halt in HALT SHALL flush the FIFO (fill = 0 next cycle), clear win_cnt and move the FSM to IDLE.
REQ-027 start outside IDLE and clr_halt outside HALT SHALL be ignored.
REQ-028 A simultaneous push and pop SHALL leave fill unchanged.
REQ-029 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 The width of win_cnt SHALL be $clog2(WIN_LEN+1).

Reset
REQ-031 rst SHALL asynchronously force IDLE, fill = 0, FIFO pointers = 0, win_cnt = 0, acc_en = 0, acc_data = 0, win_done = 0, halted = 0 and busy = 0.
REQ-032 A reset mid-window SHALL discard buffered samples with no further acc_en pulses.
REQ-033 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-034 The state enum (IDLE, RUN, HALT) SHALL live in the shared package accum_pkg.
REQ-035 The FIFO SHALL be the sub-module sync_fifo, parameterised by DATA_WIDTH and FIFO_DEPTH, exposing push, pop, flush, full, empty and fill.

Verification
REQ-036 Push 3,5,7,1, then pulse start -> acc_en high for 4 consecutive cycles starting 2 cycles after start, with acc_data 3,5,7,1.
REQ-037 WIN_LEN=4, 6 samples streamed with start -> exactly 4 acc_en pulses, win_done coincident with the 4th, FSM in IDLE, fill = 2.
REQ-038 in_valid held high with no start -> in_ready falls after 4 accepts, fill = 4, no acc_en.
REQ-039 acc_ovf raised on the same cycle as the final window pop -> no pop, no win_done, halted = 1 next cycle, fill unchanged.
REQ-040 In HALT with fill = 3, pulse clr_halt -> fill = 0, halted = 0 and FSM in IDLE next cycle.
REQ-041 rst asserted mid-window between clock edges -> all outputs zero immediately, no acc_en after release until the next start.
